dff_init_seq: RTL and testbench
===============================

Name: dff_init_seq

Overview:
- Sequencer that drives the asynchronous PRESET/CLEAR inputs of DFFP/DFFC flop groups in the Gowin primitive library.
- Holds all selected groups in preset together, then releases them one group at a time with a fixed gap between releases.
- Serves power-on initialisation and software-requested re-initialisation of register banks in the Verilator models.
- Sits between the top-level reset/control logic and the flop banks.

Parameters:
- NUM_GRP, 4: number of flop groups; range 1..16.
- HOLD_CYC, 8: cycles all selected groups stay asserted; minimum 1.
- GAP_CYC, 2: cycles between consecutive group releases; minimum 1.
- INIT_ON_RESET, 1: 1 = run a full sequence on reset exit; 0 = come out of reset idle.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RESETN  input  1  synchronous, active-low reset.
- REQ  input  1  re-init request; level; sampled only in IDLE.
- MASK  input  NUM_GRP  1 = skip this group; latched when REQ is accepted.
- GRP_RST  output  NUM_GRP  per-group preset/clear drive; active high; registered.
- DONE  output  NUM_GRP  1 = group released or skipped; registered.
- BUSY  output  1  sequence in progress.
- ACK  output  1  one-cycle pulse at end of sequence.

Behaviour:
- FSM states: IDLE, ASSERT, RELEASE, FIN. Down-counter width = clog2(max(HOLD_CYC,GAP_CYC)+1).
- Reset (RESETN low at an edge), INIT_ON_RESET=1:
  - GRP_RST = all ones, DONE = 0, BUSY = 1, ACK = 0.
  - State = ASSERT, counter = HOLD_CYC, latched mask = 0.
- Reset, INIT_ON_RESET=0: GRP_RST = 0, DONE = all ones, BUSY = 0, ACK = 0, state = IDLE.
- IDLE: REQ=1 at edge k:
  - Latch MASK.
  - GRP_RST = ~MASK at k+1; DONE = MASK at k+1.
  - BUSY = 1 at k+1; state = ASSERT with counter = HOLD_CYC.
- REQ with MASK all ones: go straight to FIN. ACK = 1 at k+1, BUSY stays 0, GRP_RST unchanged.
- ASSERT: counter decrements each cycle.
  - The first cycle after entry counts as hold cycle 1, so GRP_RST is high for exactly HOLD_CYC cycles.
  - At expiry, the lowest unmasked group's GRP_RST bit goes to 0 and its DONE bit to 1, in the same cycle. State = RELEASE, counter = GAP_CYC.
- RELEASE: at counter expiry, release the next higher unmasked index. Masked indices are skipped with zero cycle cost.
- After the last release: FIN for exactly one cycle, with ACK = 1 and BUSY = 0. Then IDLE.
- REQ is ignored in ASSERT, RELEASE and FIN. REQ held high restarts the sequence one cycle after the ACK cycle.
- MASK changes while BUSY have no effect.
- RESETN low mid-sequence: full reset values apply at that edge; with INIT_ON_RESET=1 the whole sequence restarts.
- GRP_RST and DONE are glitch-free (register outputs only). No combinational path from inputs to outputs.

Optional Feature:
- Macro: DFF_INIT_SEQ_ABORT_EN.
- Defined: adds input ABORT (1 bit). ABORT=1 in ASSERT or RELEASE:
  - Next edge: GRP_RST = ~latched mask, DONE = latched mask, state = ASSERT, counter = HOLD_CYC.
  - No ACK for the aborted sequence.
  - ABORT in IDLE or FIN is ignored.
- Not defined: no ABORT port. The sequence always runs to completion unless RESETN is asserted.

Decomposition:
- Shared package/include dff_init_pkg:
  - State encodings ST_IDLE=2'd0, ST_ASSERT=2'd1, ST_RELEASE=2'd2, ST_FIN=2'd3.
  - clog2 constant function.
  - MAX_GRP=16.
- One sub-module dff_init_cnt: loadable down-counter with load value, load strobe and a zero flag. Instantiated once.
- The priority pick of the next unmasked index stays inline in dff_init_seq.

Test Plan (NUM_GRP=4, HOLD_CYC=8, GAP_CYC=2):
- Reset sequence, INIT_ON_RESET=1: RESETN low 3 cycles, then high.
  - During reset: GRP_RST=4'hF, DONE=0, BUSY=1.
  - bit0 drops at post-reset cycle 8, bit1 at 10, bit2 at 12, bit3 at 14.
  - ACK=1 and BUSY=0 at cycle 15; IDLE at cycle 16.
- Masked request: REQ pulse with MASK=4'b0101.
  - Next cycle: GRP_RST=4'b1010, DONE=4'b0101.
  - bit1 released 8 cycles later, bit3 2 cycles after that, ACK on the following cycle.
- All masked: REQ with MASK=4'hF → ACK=1 next cycle, GRP_RST stays 0, BUSY never 1.
- REQ held high continuously → back-to-back sequences, exactly one ACK cycle between them; REQ pulses mid-sequence ignored.
- Reset mid-sequence: RESETN low during RELEASE after bit1 released → next edge GRP_RST=4'hF, DONE=0; full timing from scenario 1 repeats.
- With DFF_INIT_SEQ_ABORT_EN: ABORT=1 two cycles into RELEASE → GRP_RST=4'hF next edge, no ACK, hold restarts for 8 cycles. Without the macro, the bench checks the port is absent.

Source files
------------

// File: rtl/dff_init_pkg.sv
// Shared types and constants for the DFFP/DFFC preset/clear release sequencer.
package dff_init_pkg;

  localparam int unsigned MAX_GRP = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_FIN     = 2'd3
  } state_e;

  // Bits needed to hold values 0..val-1
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if (((val - 32'd1) >> i) != 32'd0) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dff_init_cnt.sv
// Loadable down-counter used for the hold and gap timing of dff_init_seq.
module dff_init_cnt #(
  parameter int unsigned   W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the cycle whose closing edge brings the count to zero
  assign zero_o = (cnt_q <= W'(1));

endmodule

// File: rtl/dff_init_seq.sv
// Holds selected flop groups in preset, then releases them lowest index first with a fixed gap.
// Optional ABORT input restarts the hold phase when DFF_INIT_SEQ_ABORT_EN is defined.
module dff_init_seq
  import dff_init_pkg::*;
#(
  parameter int unsigned NUM_GRP       = 4,
  parameter int unsigned HOLD_CYC      = 8,
  parameter int unsigned GAP_CYC       = 2,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               REQ,
  input  logic [NUM_GRP-1:0] MASK,
`ifdef DFF_INIT_SEQ_ABORT_EN
  input  logic               ABORT,
`endif
  output logic [NUM_GRP-1:0] GRP_RST,
  output logic [NUM_GRP-1:0] DONE,
  output logic               BUSY,
  output logic               ACK
);

  localparam int unsigned MAX_CYC  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CNT_W    = clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] GAP_VAL  = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_RST  = (INIT_ON_RESET != 0) ? HOLD_VAL : '0;

  state_e             state_q, state_d;
  logic [NUM_GRP-1:0] grp_q, grp_d;
  logic [NUM_GRP-1:0] done_q, done_d;
  logic [NUM_GRP-1:0] mask_q, mask_d;
  logic [NUM_GRP-1:0] rel_vec;
  logic               found;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_zero;
  logic               abort;

`ifdef DFF_INIT_SEQ_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  dff_init_cnt #(
    .W       (CNT_W),
    .RST_VAL (CNT_RST)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_ni     (RESETN),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // Groups still held are exactly the unmasked, unreleased ones, so the next to
  // release is the lowest set bit of the held vector.
  always_comb begin
    rel_vec = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_GRP; i++) begin
      if (grp_q[i] && !found) begin
        rel_vec[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grp_d        = grp_q;
    done_d       = done_q;
    mask_d       = mask_q;
    cnt_load     = 1'b0;
    cnt_load_val = HOLD_VAL;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          mask_d = MASK;
          if (&MASK) begin
            state_d = ST_FIN;
          end else begin
            grp_d        = ~MASK;
            done_d       = MASK;
            state_d      = ST_ASSERT;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_VAL;
          end
        end
      end
      ST_ASSERT: begin
        if (cnt_zero) begin
          grp_d        = grp_q & ~rel_vec;
          done_d       = done_q | rel_vec;
          state_d      = ST_RELEASE;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_VAL;
        end
      end
      ST_RELEASE: begin
        if (!found) begin
          state_d = ST_FIN;
        end else if (cnt_zero) begin
          grp_d        = grp_q & ~rel_vec;
          done_d       = done_q | rel_vec;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_VAL;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && ((state_q == ST_ASSERT) || (state_q == ST_RELEASE))) begin
      grp_d        = ~mask_q;
      done_d       = mask_q;
      state_d      = ST_ASSERT;
      cnt_load     = 1'b1;
      cnt_load_val = HOLD_VAL;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      mask_q <= '0;
      if (INIT_ON_RESET != 0) begin
        state_q <= ST_ASSERT;
        grp_q   <= '1;
        done_q  <= '0;
      end else begin
        state_q <= ST_IDLE;
        grp_q   <= '0;
        done_q  <= '1;
      end
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
    end
  end

  assign GRP_RST = grp_q;
  assign DONE    = done_q;
  assign BUSY    = (state_q == ST_ASSERT) || (state_q == ST_RELEASE);
  assign ACK     = (state_q == ST_FIN);

endmodule

// File: tb/tb_dff_init_seq.sv
// Directed self-checking bench for dff_init_seq (NUM_GRP=4, HOLD_CYC=8, GAP_CYC=2).
// Exercises ABORT only when DFF_INIT_SEQ_ABORT_EN is defined.
module tb_dff_init_seq;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       REQ = 1'b0;
  logic [3:0] MASK = 4'h0;
`ifdef DFF_INIT_SEQ_ABORT_EN
  logic       ABORT = 1'b0;
`endif
  logic [3:0] GRP_RST;
  logic [3:0] DONE;
  logic       BUSY;
  logic       ACK;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dff_init_seq #(
    .NUM_GRP       (4),
    .HOLD_CYC      (8),
    .GAP_CYC       (2),
    .INIT_ON_RESET (1)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .REQ     (REQ),
    .MASK    (MASK),
`ifdef DFF_INIT_SEQ_ABORT_EN
    .ABORT   (ABORT),
`endif
    .GRP_RST (GRP_RST),
    .DONE    (DONE),
    .BUSY    (BUSY),
    .ACK     (ACK)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int s, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at step %0d: observed %0h expected %0h", tag, s, obs, exp);
    end
  endtask

  // Group i is held for s < 8 + 2*i, s counting edges since hold entry
  function automatic logic [3:0] exp_grp(input int s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (s < 8 + 2 * i);
    return r;
  endfunction

  task automatic chk_full(input string tag, input int s);
    logic [3:0] eg;
    logic [3:0] ed;
    eg = exp_grp(s);
    ed = ~eg;
    chk({tag, "_grp"},  s, 32'(GRP_RST), 32'(eg));
    chk({tag, "_done"}, s, 32'(DONE),    32'(ed));
    chk({tag, "_busy"}, s, 32'(BUSY),    32'(s <= 14));
    chk({tag, "_ack"},  s, 32'(ACK),     32'(s == 15));
  endtask

  task automatic run_seq(input string tag, input int s0, input int s1);
    for (int s = s0; s <= s1; s++) begin
      step();
      chk_full(tag, s);
    end
  endtask

  task automatic chk_reset(input string tag, input int s);
    chk({tag, "_grp"},  s, 32'(GRP_RST), 32'h0000_000F);
    chk({tag, "_done"}, s, 32'(DONE),    32'h0000_0000);
    chk({tag, "_busy"}, s, 32'(BUSY),    32'h0000_0001);
    chk({tag, "_ack"},  s, 32'(ACK),     32'h0000_0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eg;
    logic [3:0] ed;
    int         s;

    // Power-on reset with init sequence
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset("por", i);
    end
    RESETN = 1'b1;
    run_seq("init", 1, 16);

    // Masked request; MASK change mid-sequence must not matter
    MASK = 4'b0101;
    REQ  = 1'b1;
    step();
    REQ = 1'b0;
    chk("msk_grp0",  0, 32'(GRP_RST), 32'h0000_000A);
    chk("msk_done0", 0, 32'(DONE),    32'h0000_0005);
    chk("msk_busy0", 0, 32'(BUSY),    32'h0000_0001);
    for (int j = 1; j <= 12; j++) begin
      if (j == 3) MASK = 4'b0000;
      step();
      eg = {(j < 10), 1'b0, (j < 8), 1'b0};
      ed = {(j >= 10), 1'b1, (j >= 8), 1'b1};
      if (j == 12) ed = 4'hF;
      chk("msk_grp",  j, 32'(GRP_RST), 32'(eg));
      chk("msk_done", j, 32'(DONE),    32'(ed));
      chk("msk_busy", j, 32'(BUSY),    32'(j <= 10));
      chk("msk_ack",  j, 32'(ACK),     32'(j == 11));
    end

    // All groups masked: immediate ACK, never busy
    MASK = 4'hF;
    REQ  = 1'b1;
    step();
    REQ = 1'b0;
    chk("allm_ack",  0, 32'(ACK),     32'h0000_0001);
    chk("allm_busy", 0, 32'(BUSY),    32'h0000_0000);
    chk("allm_grp",  0, 32'(GRP_RST), 32'h0000_0000);
    chk("allm_done", 0, 32'(DONE),    32'h0000_000F);
    step();
    chk("allm_ack",  1, 32'(ACK),     32'h0000_0000);
    chk("allm_busy", 1, 32'(BUSY),    32'h0000_0000);
    MASK = 4'h0;

    // REQ held high: back-to-back runs, one ACK then one IDLE cycle between
    REQ = 1'b1;
    for (int j = 0; j <= 33; j++) begin
      step();
      s = (j <= 16) ? j : j - 17;
      chk_full("b2b", s);
      if (j == 17) REQ = 1'b0;
      if (j == 20) REQ = 1'b1;
      if (j == 21) REQ = 1'b0;
    end

    // Reset during RELEASE after bit1 released
    REQ = 1'b1;
    step();
    REQ = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      step();
      if (j == 10) chk("rmid_grp", j, 32'(GRP_RST), 32'h0000_000C);
    end
    RESETN = 1'b0;
    step();
    chk_reset("rmid_rst", 0);
    RESETN = 1'b1;
    run_seq("rmid", 1, 16);

`ifdef DFF_INIT_SEQ_ABORT_EN
    // Abort two cycles into RELEASE: hold restarts, no ACK for the aborted run
    REQ = 1'b1;
    step();
    REQ = 1'b0;
    for (int j = 1; j <= 26; j++) begin
      if (j == 10) ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      s = (j < 10) ? j : j - 10;
      chk_full("abort", s);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
